// File: rtl/step_input_conditioner_if.sv
// Handshake bundle between the ui_in wrapper and the step input conditioner.
// master drives the raw inputs; slave (the conditioner) returns the clean step.
interface step_input_conditioner_if;
    logic ena;
    logic btn_in;
    logic dir_in;
    logic step_pulse;
    logic step_dir;
    logic btn_level;

    modport master (
        output ena,
        output btn_in,
        output dir_in,
        input  step_pulse,
        input  step_dir,
        input  btn_level
    );

    modport slave (
        input  ena,
        input  btn_in,
        input  dir_in,
        output step_pulse,
        output step_dir,
        output btn_level
    );
endinterface

// File: rtl/step_input_conditioner.sv
// Synchronises, debounces and edge-detects a push button into a one-cycle step strobe.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat pulses while the button stays pressed.
module step_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_PERIOD   = 4
) (
    input logic                     clk,
    input logic                     rst,
    step_input_conditioner_if.slave bus
);

    typedef enum logic {
        STABLE_LOW  = 1'b0,
        STABLE_HIGH = 1'b1
    } deb_state_e;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2**CNT_W - 1) ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("step_input_conditioner: illegal parameter value");
    end

    deb_state_e       state_q, state_d;
    logic             btn_sync1_q, btn_sync2_q;
    logic             dir_sync1_q, dir_sync2_q;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             step_pulse_q, step_pulse_d;
    logic             step_dir_q, step_dir_d;
    logic             level_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_sync1_q <= 1'b0;
            btn_sync2_q <= 1'b0;
            dir_sync1_q <= 1'b0;
            dir_sync2_q <= 1'b0;
        end else begin
            btn_sync1_q <= bus.btn_in;
            btn_sync2_q <= btn_sync1_q;
            dir_sync1_q <= bus.dir_in;
            dir_sync2_q <= dir_sync1_q;
        end
    end

    // Any sample that agrees with the current level restarts qualification.
    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        level_rise = 1'b0;
        if (!bus.ena) begin
            deb_cnt_d = '0;
        end else if (btn_sync2_q == (state_q == STABLE_HIGH)) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_d = '0;
            case (state_q)
                STABLE_LOW: begin
                    state_d    = STABLE_HIGH;
                    level_rise = 1'b1;
                end
                default: state_d = STABLE_LOW;
            endcase
        end else begin
            deb_cnt_d = deb_cnt_q + CNT_ONE;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_phase_q, rep_phase_d;
    logic             rep_fire;

    // The initial pulse restarts the repeat timer; leaving the pressed level kills it.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        rep_fire    = 1'b0;
        if (!bus.ena || state_d == STABLE_LOW || level_rise) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end else if (rep_cnt_q == (rep_phase_q ? PER_LAST : DLY_LAST)) begin
            rep_fire    = 1'b1;
            rep_cnt_d   = '0;
            rep_phase_d = 1'b1;
        end else begin
            rep_cnt_d = rep_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end
`endif

    always_comb begin
        step_pulse_d = 1'b0;
        step_dir_d   = step_dir_q;
`ifdef AUTO_REPEAT_EN
        if (level_rise || rep_fire) begin
`else
        if (level_rise) begin
`endif
            step_pulse_d = 1'b1;
            step_dir_d   = dir_sync2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= STABLE_LOW;
            deb_cnt_q    <= '0;
            step_pulse_q <= 1'b0;
            step_dir_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            deb_cnt_q    <= deb_cnt_d;
            step_pulse_q <= step_pulse_d;
            step_dir_q   <= step_dir_d;
        end
    end

    assign bus.step_pulse = step_pulse_q;
    assign bus.step_dir   = step_dir_q;
    assign bus.btn_level  = (state_q == STABLE_HIGH);

endmodule

// File: tb/tb_step_input_conditioner.sv
// Directed bench for step_input_conditioner with DEBOUNCE_CYCLES = 4.
// Expected pulse timings are hand-derived; the hold test also covers AUTO_REPEAT_EN builds.
module tb_step_input_conditioner;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    step_input_conditioner_if bus ();

    step_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16),
        .REPEAT_DELAY   (8),
        .REPEAT_PERIOD  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic b, input logic d);
        rst        = r;
        bus.ena    = e;
        bus.btn_in = b;
        bus.dir_in = d;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic expPulse, input logic expLevel,
                            input logic expDir);
        checkOutput({tag, ".step_pulse"}, bus.step_pulse, expPulse);
        checkOutput({tag, ".btn_level"}, bus.btn_level, expLevel);
        checkOutput({tag, ".step_dir"}, bus.step_dir, expDir);
    endtask

    // Button rises before edge E0: level and pulse appear after E5, pulse gone after E6.
    task automatic pressCheck(input logic d, input logic prevDir, input string tag);
        applyStimulus(1'b0, 1'b1, 1'b1, d);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkAll({tag, "_wait"}, 1'b0, 1'b0, prevDir);
        end
        tick();
        checkAll({tag, "_pulse"}, 1'b1, 1'b1, d);
        tick();
        checkAll({tag, "_after"}, 1'b0, 1'b1, d);
    endtask

    task automatic releaseCheck(input logic dNew, input logic expDir, input string tag);
        applyStimulus(1'b0, 1'b1, 1'b0, dNew);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkAll({tag, "_wait"}, 1'b0, 1'b1, expDir);
        end
        tick();
        checkAll({tag, "_low"}, 1'b0, 1'b0, expDir);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkAll({tag, "_idle"}, 1'b0, 1'b0, expDir);
        end
    endtask

    initial begin
        logic expPulse;
        vectors     = 0;
        miscompares = 0;

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkAll("reset", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkAll("idle", 1'b0, 1'b0, 1'b0);
        end

        pressCheck(1'b1, 1'b0, "clean");
        releaseCheck(1'b1, 1'b1, "clean_rel");

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        checkAll("bounce1", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checkAll("bounce0", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        checkAll("bounce1b", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checkAll("bounce0b", 1'b0, 1'b0, 1'b1);
        pressCheck(1'b1, 1'b1, "bounce");
        releaseCheck(1'b1, 1'b1, "bounce_rel");

        pressCheck(1'b0, 1'b1, "dir0");
        releaseCheck(1'b1, 1'b0, "dir0_rel");
        pressCheck(1'b1, 1'b0, "dir1");
        releaseCheck(1'b0, 1'b1, "dir1_rel");

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkAll("rst_pre", 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        checkAll("rst_mid", 1'b0, 1'b0, 1'b0);
        pressCheck(1'b1, 1'b0, "rst_resume");
        releaseCheck(1'b1, 1'b1, "rst_rel");

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkAll("ena_pre", 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkAll("ena_off", 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkAll("ena_requal", 1'b0, 1'b0, 1'b1);
        end
        tick();
        checkAll("ena_resume", 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkAll("ena_hold", 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkAll("ena_rel", 1'b0, 1'b1, 1'b0);
        end
        tick();
        checkAll("ena_rel_low", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkAll("ena_idle", 1'b0, 1'b0, 1'b0);
        end

        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 40; k++) begin
            if (k == 30) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
            tick();
`ifdef AUTO_REPEAT_EN
            expPulse = (k == 5) || (k >= 13 && k < 35 && ((k - 13) % 4) == 0);
`else
            expPulse = (k == 5);
`endif
            checkAll($sformatf("hold_k%0d", k), expPulse, (k >= 5 && k < 35), (k >= 5));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
